// File: rtl/cache_types.sv
// rtl/cache_types.sv - L2 set and way index types
`ifndef CACHE_TYPES_SV
`define CACHE_TYPES_SV
`include "cache_consts.sv"

package cache_types;
    localparam int L2_SET_W = $clog2(`L2_SETS);
    localparam int L2_WAY_W = $clog2(`L2_WAYS);

    typedef logic [L2_SET_W-1:0] l2_set_t;
    typedef logic [L2_WAY_W-1:0] l2_way_t;
endpackage

`endif

// File: rtl/l2_evict_ptr_pkg.sv
// rtl/l2_evict_ptr_pkg.sv - FSM states and pointer arithmetic for l2_evict_ptr
`ifndef L2_EVICT_PTR_PKG_SV
`define L2_EVICT_PTR_PKG_SV
`include "cache_types.sv"

package l2_evict_ptr_pkg;
    import cache_types::*;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } evict_state_t;

    // Explicit compare keeps the wrap correct even when nways is not a power of two.
    function automatic l2_way_t way_advance(input l2_way_t way, input int nways);
        return (int'(way) == nways - 1) ? '0 : way + l2_way_t'(1);
    endfunction
endpackage

`endif

// File: rtl/cache_consts.sv
// rtl/cache_consts.sv - shared L2 geometry and eviction-update mode macros
`ifndef CACHE_CONSTS_SV
`define CACHE_CONSTS_SV

`define L2_WAYS 8
`define L2_SETS 256
`define L2_EVICT_ADVANCE 1'b0
`define L2_EVICT_LOAD 1'b1

`endif

// File: rtl/l2_evict_ptr_mem.sv
// rtl/l2_evict_ptr_mem.sv - per-set eviction pointer array, sync write / async read
module l2_evict_ptr_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/l2_evict_ptr.sv
// rtl/l2_evict_ptr.sv - round-robin L2 eviction pointer per set with init sweep and write-forward
`include "l2_evict_ptr_pkg.sv"

module l2_evict_ptr
    import cache_types::*;
    import l2_evict_ptr_pkg::*;
#(
    parameter int NWAYS = `L2_WAYS,
    parameter int NSETS = `L2_SETS
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rd_en,
    input  l2_set_t rd_set,
    input  logic    upd_en,
    input  l2_set_t upd_set,
    input  l2_way_t upd_way,
    input  logic    upd_mode,
    output l2_way_t evict_way_buf,
    output logic    evict_valid,
    output logic    ready
);
    localparam l2_set_t LAST_SET = l2_set_t'(NSETS - 1);

    evict_state_t state_q, state_d;
    l2_set_t      init_cnt_q;
    logic         wr_en;
    l2_set_t      wr_set;
    l2_way_t      wr_data;
    l2_way_t      rd_data;
    l2_way_t      upd_value;
    l2_way_t      fwd_way;
    logic         rd_accept;

    l2_evict_ptr_mem #(
        .DEPTH (NSETS),
        .AW    ($bits(l2_set_t)),
        .DW    ($bits(l2_way_t))
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_set),
        .wr_data (wr_data),
        .rd_addr (rd_set),
        .rd_data (rd_data)
    );

    assign upd_value = (upd_mode == `L2_EVICT_LOAD) ? upd_way : way_advance(upd_way, NWAYS);
    // A same-set update lands on the same edge as the read, so return the new value.
    assign fwd_way   = (upd_en && (upd_set == rd_set)) ? upd_value : rd_data;
    assign rd_accept = (state_q == ST_IDLE) && rd_en;
    assign ready     = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_set  = upd_set;
        wr_data = upd_value;
        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_set  = init_cnt_q;
                wr_data = '0;
                if (init_cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                wr_en = upd_en;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            evict_way_buf <= '0;
            evict_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            evict_valid <= rd_accept;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + l2_set_t'(1);
            end
            if (rd_accept) begin
                evict_way_buf <= fwd_way;
            end
        end
    end
endmodule

// File: doc/l2_evict_ptr.md
L2_EVICT_PTR -- requirements
Module: l2_evict_ptr

Interface
REQ-001 SHALL take parameter NWAYS, default `L2_WAYS: ways per set; pointer modulus.
REQ-002 SHALL take parameter NSETS, default `L2_SETS: number of sets; pointer array depth.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-low reset, sampled on posedge clk.
REQ-005 SHALL have port rd_en, input, 1 bit: request eviction way for rd_set.
REQ-006 SHALL have port rd_set, input, l2_set_t: set index of read request.
REQ-007 SHALL have port upd_en, input, 1 bit: update pointer of upd_set.
REQ-008 SHALL have port upd_set, input, l2_set_t: set index of update.
REQ-009 SHALL have port upd_way, input, l2_way_t: way just filled or forced.
REQ-010 SHALL have port upd_mode, input, 1 bit: `L2_EVICT_ADVANCE (0) or `L2_EVICT_LOAD (1).
REQ-011 SHALL have port evict_way_buf, output, l2_way_t: registered eviction way, driving the lookup stage's evict_way_buf input.
REQ-012 SHALL have port evict_valid, output, 1 bit: one-cycle pulse marking a new evict_way_buf.
REQ-013 SHALL have port ready, output, 1 bit: high when the pointer array is initialised and requests are accepted.

Function
REQ-014 SHALL implement a two-state FSM, INIT and IDLE; reset enters INIT.
REQ-015 In INIT: SHALL write 0 to one set per cycle, set 0 up to NSETS-1; ready=0; rd_en and upd_en are ignored.
REQ-016 SHALL move from INIT to IDLE in the cycle after writing set NSETS-1, so ready rises exactly NSETS cycles after rst deasserts.
REQ-017 In IDLE, rd_en=1 in cycle N: SHALL present evict_way_buf = ptr[rd_set] with evict_valid=1 in cycle N+1.
REQ-018 SHALL hold evict_way_buf when no read is accepted; evict_valid SHALL be 0 in any cycle not following an accepted read.
REQ-019 ADVANCE: SHALL set ptr[upd_set] to (upd_way+1) mod NWAYS, so way NWAYS-1 wraps to 0.
REQ-020 LOAD: SHALL set ptr[upd_set] to upd_way.
REQ-021 SHALL make an update visible at the next rising edge.
REQ-022 Accepted rd_en and upd_en in the same cycle with rd_set == upd_set: SHALL return the updated value (write-forward).
REQ-023 Same-cycle read and update of different sets SHALL proceed independently.
REQ-024 Back-to-back reads SHALL be accepted every cycle; throughput is 1 read and 1 update per cycle.
REQ-025 SHALL use width-exact arithmetic; with NWAYS a power of two, the wrap is natural truncation to the way width.

Reset
REQ-026 While rst=0 at a clock edge: SHALL force evict_way_buf=0, evict_valid=0, ready=0, state=INIT, init counter=0.
REQ-027 Reset asserted mid-INIT or mid-operation SHALL restart initialisation from set 0 and drop any in-flight read, with no evict_valid pulse after the reset edge.

Structure
REQ-028 SHALL take l2_set_t and l2_way_t from cache_types, and `L2_EVICT_ADVANCE, `L2_EVICT_LOAD, `L2_WAYS, `L2_SETS from cache_consts.
REQ-029 SHALL place the pointer array in sub-module l2_evict_ptr_mem: NSETS x way-width entries, one synchronous write port, one asynchronous read port.
REQ-030 SHALL keep the FSM, init counter, forwarding mux and output registers in l2_evict_ptr.

Verification (NWAYS=8, NSETS=256)
REQ-031 Release rst, then hold rd_en=1 and upd_en=1 from cycle 0 -> ready=0 for 256 cycles, rises in cycle 256, no evict_valid before then, no pointer changes.
REQ-032 After init, rd set 5 -> next cycle evict_way_buf=0 and evict_valid=1; following idle cycle evict_valid=0 and evict_way_buf holds 0.
REQ-033 ADVANCE set 5 way 7, then rd set 5 -> evict_way_buf=0 (wrap); ADVANCE set 5 way 3, then rd -> 4.
REQ-034 Same cycle: LOAD set 9 way 6 plus rd set 9 -> next cycle evict_way_buf=6; same cycle: ADVANCE set 10 way 2 plus rd set 11 -> 0.
REQ-035 Assert rst for one cycle at init set 100, then release -> ready stays low for 256 cycles; after that rd of a previously loaded set -> 0.
REQ-036 Random rd/upd traffic against a reference pointer array for 10k cycles -> every evict_valid pulse matches the model and is the only one per accepted read.
